// File: rtl/da_fir_pkg.sv
// Shared sizing, types and FSM states for the DA FIR LUT loader.
package da_fir_pkg;
  localparam int NUM_COEF   = 10;
  localparam int COEF_W     = 17;
  localparam int GROUP_SIZE = 5;
  localparam int NUM_GRP    = NUM_COEF / GROUP_SIZE;
  localparam int LUT_W      = COEF_W + $clog2(GROUP_SIZE);
  localparam int BUILD_LEN  = NUM_GRP << GROUP_SIZE;
  localparam int IDX_W      = $clog2(BUILD_LEN + 1);
  localparam int GRP_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int CADDR_W    = 4;
  localparam int CSUM_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/da_lut_entry_sum.sv
// Combinational masked adder: sums the sign-extended coefficients selected by
// the LUT address bits.
module da_lut_entry_sum
  import da_fir_pkg::*;
(
  input  logic [GROUP_SIZE-1:0][COEF_W-1:0] coef_i,
  input  logic [GROUP_SIZE-1:0]             addr_i,
  output logic [LUT_W-1:0]                  sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (addr_i[i]) begin
        sum_o = sum_o + {{(LUT_W-COEF_W){coef_i[i][COEF_W-1]}}, coef_i[i]};
      end
    end
  end
endmodule

// File: rtl/da_lut_loader.sv
// DA LUT loader: stores folded coefficients and streams every LUT entry to the
// filter on request. Optional checksum output under DA_LUT_CHECKSUM_EN.
//
// state | meaning
// IDLE  | accept coefficient writes, wait for start
// BUILD | emit one LUT entry per cycle, group-major, address ascending
// DONE  | one-cycle completion pulse, cfg_valid set
module da_lut_loader
  import da_fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coef_wr_en,
  input  logic [CADDR_W-1:0]  coef_wr_addr,
  input  logic [COEF_W-1:0]   coef_wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                cfg_valid,
  output logic                lut_we,
  output logic [GRP_W-1:0]    lut_grp,
  output logic [GROUP_SIZE-1:0] lut_addr,
  output logic [LUT_W-1:0]    lut_data
`ifdef DA_LUT_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]   lut_checksum
`endif
);
  logic [COEF_W-1:0]     coef_q [NUM_COEF];
  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  busy_q, done_q, cfg_valid_q, lut_we_q;
  logic [GRP_W-1:0]      lut_grp_q;
  logic [GROUP_SIZE-1:0] lut_addr_q;
  logic [LUT_W-1:0]      lut_data_q;

  logic [GRP_W-1:0]                  idx_grp;
  logic [GROUP_SIZE-1:0][COEF_W-1:0] coef_slice;
  logic [LUT_W-1:0]                  entry_sum;

  assign idx_grp = idx_q[GROUP_SIZE +: GRP_W];

  always_comb begin
    coef_slice = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (idx_grp == GRP_W'(g)) begin
        for (int i = 0; i < GROUP_SIZE; i++) coef_slice[i] = coef_q[g*GROUP_SIZE + i];
      end
    end
  end

  da_lut_entry_sum u_entry_sum (
    .coef_i (coef_slice),
    .addr_i (idx_q[GROUP_SIZE-1:0]),
    .sum_o  (entry_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      lut_we_q    <= 1'b0;
      lut_grp_q   <= '0;
      lut_addr_q  <= '0;
      lut_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          for (int i = 0; i < NUM_COEF; i++) begin
            if (coef_wr_en && coef_wr_addr == CADDR_W'(i)) begin
              coef_q[i]   <= coef_wr_data;
              cfg_valid_q <= 1'b0;
            end
          end
          // Entry 0 is always zero, so it is issued here and the build
          // proper starts at index 1 with any same-cycle write already stored.
          if (start) begin
            state_q     <= BUILD;
            busy_q      <= 1'b1;
            cfg_valid_q <= 1'b0;
            lut_we_q    <= 1'b1;
            lut_grp_q   <= '0;
            lut_addr_q  <= '0;
            lut_data_q  <= '0;
            idx_q       <= IDX_W'(1);
          end
        end
        BUILD: begin
          if (idx_q == IDX_W'(BUILD_LEN)) begin
            state_q     <= DONE;
            lut_we_q    <= 1'b0;
            done_q      <= 1'b1;
            cfg_valid_q <= 1'b1;
          end else begin
            lut_we_q   <= 1'b1;
            lut_grp_q  <= idx_grp;
            lut_addr_q <= idx_q[GROUP_SIZE-1:0];
            lut_data_q <= entry_sum;
            idx_q      <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_valid = cfg_valid_q;
  assign lut_we    = lut_we_q;
  assign lut_grp   = lut_grp_q;
  assign lut_addr  = lut_addr_q;
  assign lut_data  = lut_data_q;

`ifdef DA_LUT_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (lut_we_q) begin
      csum_q <= csum_q + {{(CSUM_W-LUT_W){lut_data_q[LUT_W-1]}}, lut_data_q};
    end
  end

  assign lut_checksum = csum_q;
`endif
endmodule
